// File: rtl/reset_seq_gen.sv
// reset_seq_gen: staged reset sequencer, optional watchdog via RESET_SEQ_GEN_WDOG_EN
module reset_seq_gen #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_locked,
  input  logic                  sw_rst_req,
  input  logic                  wdog_kick,
  output logic [NUM_STAGES-1:0] rst_n_out,
  output logic                  seq_done,
  output logic [1:0]            rst_cause
);
  localparam int CMAX = HOLD_CYCLES > STAGE_GAP ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW = $clog2(CMAX) + 1;
  localparam int SW = $clog2(NUM_STAGES) + 1;
  localparam logic [1:0] HOLD    = 2'd0;
  localparam logic [1:0] RELEASE = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;
  logic [1:0]            sync_q, sync_d;
  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
  logic                  seq_done_q, seq_done_d;
  logic [1:0]            cause_q, cause_d;
  logic                  lock_s, abort, wdog_exp;
  assign lock_s = sync_q[1];
`ifdef RESET_SEQ_GEN_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES) + 1;
  logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
  // Watchdog counts unkicked RUN edges; it sits at zero outside RUN so RUN entry starts clean
  always_comb begin
    wdog_exp   = state_q == RUN && wdog_cnt_q == WW'(WDOG_CYCLES - 1) && !wdog_kick;
    wdog_cnt_d = (state_q == RUN && !wdog_kick && !abort) ? wdog_cnt_q + WW'(1) : '0;
  end
  // Watchdog counter register
  always_ff @(posedge clk or posedge reset)
    if (reset) wdog_cnt_q <= '0;
    else       wdog_cnt_q <= wdog_cnt_d;
`else
  logic unused_kick;
  assign unused_kick = wdog_kick;
  assign wdog_exp    = 1'b0;
`endif
  // Sequencer next-state: abort dominates, otherwise hold-count or stage-by-stage release
  always_comb begin
    sync_d     = {sync_q[0], pll_locked};
    state_d    = state_q;
    cnt_d      = cnt_q;
    stage_d    = stage_q;
    rst_n_d    = rst_n_q;
    seq_done_d = seq_done_q;
    cause_d    = cause_q;
    abort      = state_q != HOLD && (!lock_s || sw_rst_req || wdog_exp);
    if (abort) begin
      state_d    = HOLD;
      cnt_d      = '0;
      stage_d    = '0;
      rst_n_d    = '0;
      seq_done_d = 1'b0;
      cause_d    = !lock_s ? 2'd1 : sw_rst_req ? 2'd2 : 2'd3;
    end else if (state_q == HOLD) begin
      if (!lock_s || sw_rst_req) cnt_d = '0;
      else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
        cnt_d      = '0;
        stage_d    = SW'(1);
        rst_n_d[0] = 1'b1;
        state_d    = NUM_STAGES == 1 ? RUN : RELEASE;
        seq_done_d = NUM_STAGES == 1;
      end else cnt_d = cnt_q + CW'(1);
    end else if (state_q == RELEASE) begin
      if (cnt_q == CW'(STAGE_GAP - 1)) begin
        cnt_d      = '0;
        stage_d    = stage_q + SW'(1);
        rst_n_d    = rst_n_q | (NUM_STAGES'(1) << stage_q);
        state_d    = stage_q == SW'(NUM_STAGES - 1) ? RUN : RELEASE;
        seq_done_d = stage_q == SW'(NUM_STAGES - 1);
      end else cnt_d = cnt_q + CW'(1);
    end
  end
  // Sequencer and synchronizer registers; outputs come straight from flops
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync_q     <= '0;
      state_q    <= HOLD;
      cnt_q      <= '0;
      stage_q    <= '0;
      rst_n_q    <= '0;
      seq_done_q <= 1'b0;
      cause_q    <= 2'd0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stage_q    <= stage_d;
      rst_n_q    <= rst_n_d;
      seq_done_q <= seq_done_d;
      cause_q    <= cause_d;
    end
  assign rst_n_out = rst_n_q;
  assign seq_done  = seq_done_q;
  assign rst_cause = cause_q;
endmodule
